// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: synchronizes and de-glitches PS2Clk, shifts in
// start/8 data/parity/stop bits on filtered falling edges and reports byte, parity or framing status.
module ps2_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       PS2Clk,
    input  logic       PS2Data,
    input  logic       Enable,
    output logic [7:0] Data,
    output logic       Valid,
    output logic       ParityErr,
    output logic       FrameErr,
    output logic       Busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic [7:0]    FILT_LAST = 8'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);

    // Odd parity over the data byte and its parity bit holds when the total XOR is 1.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_q, filt_d;
    logic [7:0]    fcnt_q, fcnt_d;
    logic          fall_q, fall_d;
    logic [1:0]    state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic          busy_q, busy_d;
    logic          timeout_s;

    // Two-flop synchronizers for both PS/2 lines; idle-high after reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= PS2Clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= PS2Data;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Glitch filter: the level only follows after FILTER_LEN consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = 8'd0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q >= FILT_LAST) begin
                filt_d = ~filt_q;
                fcnt_d = 8'd0;
            end else begin
                fcnt_d = fcnt_q + 8'd1;
            end
        end else begin
            fcnt_d = 8'd0;
        end
        fall_d = filt_q & ~filt_d;
    end

    // Frame FSM, timeout supervision and output pulse generation.
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        perr_d   = 1'b0;
        ferr_d   = 1'b0;

        if (!Enable || (state_q == ST_IDLE) || fall_q) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_MAX) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end else begin
            to_cnt_d = to_cnt_q;
        end

        // A strobe landing on the limit cycle wins: the frame made progress.
        timeout_s = (state_q != ST_IDLE) && (to_cnt_q >= TO_LAST) && !fall_q;

        if (!Enable) begin
            state_d  = ST_IDLE;
            bitcnt_d = 3'd0;
        end else if (fall_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d  = ST_DATA;
                        bitcnt_d = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    shift_d = {dat_s2_q, shift_q[7:1]};
                    if (bitcnt_q == 3'd7) begin
                        state_d  = ST_PARITY;
                        bitcnt_d = 3'd0;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
                ST_PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (!dat_s2_q) begin
                        ferr_d = 1'b1;
                    end else if (odd_parity_ok(shift_q, par_q)) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end else begin
                        perr_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d  = ST_IDLE;
                    bitcnt_d = 3'd0;
                end
            endcase
        end else if (timeout_s) begin
            ferr_d   = 1'b1;
            state_d  = ST_IDLE;
            bitcnt_d = 3'd0;
        end else begin
            state_d = state_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            filt_q   <= 1'b1;
            fcnt_q   <= 8'd0;
            fall_q   <= 1'b0;
            state_q  <= ST_IDLE;
            bitcnt_q <= 3'd0;
            shift_q  <= 8'd0;
            par_q    <= 1'b0;
            to_cnt_q <= '0;
            data_q   <= 8'd0;
            valid_q  <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            filt_q   <= filt_d;
            fcnt_q   <= fcnt_d;
            fall_q   <= fall_d;
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            to_cnt_q <= to_cnt_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            busy_q   <= busy_d;
        end
    end

    assign Data      = data_q;
    assign Valid     = valid_q;
    assign ParityErr = perr_q;
    assign FrameErr  = ferr_q;
    assign Busy      = busy_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: drives PS/2 frames bit by bit and checks pulses and
// Data against a frame-level model (ones-count parity, stop bit, last good byte).
`timescale 1ns/1ps
module tb_ps2_rx;

    localparam int FL = 8;
    localparam int TO = 5000;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       PS2Clk = 1'b1;
    logic       PS2Data = 1'b1;
    logic       Enable = 1'b1;
    logic [7:0] Data;
    logic       Valid, ParityErr, FrameErr, Busy;

    int n_cmp = 0;
    int n_err = 0;
    int tot_valid = 0, tot_perr = 0, tot_ferr = 0, tot_multi = 0;
    logic [7:0] cap_q[$];
    logic [7:0] exp_data = 8'h00;

    ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .Clk(Clk), .Reset(Reset), .PS2Clk(PS2Clk), .PS2Data(PS2Data), .Enable(Enable),
        .Data(Data), .Valid(Valid), .ParityErr(ParityErr), .FrameErr(FrameErr), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    // Pulse monitor: running totals and the bytes delivered with Valid.
    always @(negedge Clk) begin
        if (Valid) begin
            tot_valid++;
            cap_q.push_back(Data);
        end
        if (ParityErr) tot_perr++;
        if (FrameErr) tot_ferr++;
        if ((int'(Valid) + int'(ParityErr) + int'(FrameErr)) > 1) tot_multi++;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // bits[0] is sent first; data changes while PS2Clk is high.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input int half);
        for (int i = 0; i < nbits; i++) begin
            PS2Data = bits[i];
            cycles(half);
            PS2Clk = 1'b0;
            cycles(half);
            PS2Clk = 1'b1;
        end
        PS2Data = 1'b1;
    endtask

    // Model: odd parity means the ones count of data plus parity is odd.
    task automatic send_byte(input logic [7:0] d, input logic bad_par, input logic bad_stop,
                             input int half, output int outcome);
        logic par, stop;
        par  = (($countones(d) % 2) == 0) ? 1'b1 : 1'b0;
        par  = par ^ bad_par;
        stop = ~bad_stop;
        send_bits({stop, par, d, 1'b0}, 11, half);
        cycles(20);
        if (!stop) outcome = 2;
        else if ((($countones(d) + int'(par)) % 2) == 1) begin
            outcome = 0;
            exp_data = d;
        end else outcome = 1;
    endtask

    task automatic test_reset;
        Reset = 1'b0;
        cycles(3);
        n_cmp++; if (Data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", Data); end
        n_cmp++; if ({Valid, ParityErr, FrameErr} !== 3'b000) begin n_err++; $display("FAIL reset_pulses: got %b want 000", {Valid, ParityErr, FrameErr}); end
        n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", Busy); end
        Reset = 1'b1;
        cycles(30);
    endtask

    task automatic test_fa;
        int v0, p0, f0, oc;
        v0 = tot_valid; p0 = tot_perr; f0 = tot_ferr;
        send_byte(8'hFA, 1'b0, 1'b0, 2000, oc);
        n_cmp++; if (tot_valid - v0 != 1) begin n_err++; $display("FAIL fa_valid_count: got %0d want 1", tot_valid - v0); end
        n_cmp++; if (Data !== 8'hFA) begin n_err++; $display("FAIL fa_data: got %h want fa", Data); end
        n_cmp++; if ((tot_perr - p0) + (tot_ferr - f0) != 0) begin n_err++; $display("FAIL fa_errors: got %0d want 0", (tot_perr - p0) + (tot_ferr - f0)); end
        n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL fa_busy: got %b want 0", Busy); end
    endtask

    task automatic test_back_to_back;
        int idx, oc;
        idx = cap_q.size();
        send_byte(8'hAA, 1'b0, 1'b0, 100, oc);
        cycles(1780);
        send_byte(8'h00, 1'b0, 1'b0, 100, oc);
        n_cmp++; if (cap_q.size() - idx != 2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", cap_q.size() - idx); end
        else begin
            n_cmp++; if (cap_q[idx] !== 8'hAA) begin n_err++; $display("FAIL b2b_first: got %h want aa", cap_q[idx]); end
            n_cmp++; if (cap_q[idx+1] !== 8'h00) begin n_err++; $display("FAIL b2b_second: got %h want 00", cap_q[idx+1]); end
        end
    endtask

    task automatic test_errors;
        int v0, p0, f0, oc;
        v0 = tot_valid; p0 = tot_perr; f0 = tot_ferr;
        send_byte(8'hF4, 1'b1, 1'b0, 100, oc);
        n_cmp++; if (tot_perr - p0 != 1 || tot_valid != v0) begin n_err++; $display("FAIL parity_err: got perr=%0d valid=%0d want 1/0", tot_perr - p0, tot_valid - v0); end
        n_cmp++; if (Data !== exp_data) begin n_err++; $display("FAIL parity_data_hold: got %h want %h", Data, exp_data); end
        send_byte(8'h08, 1'b0, 1'b1, 100, oc);
        n_cmp++; if (tot_ferr - f0 != 1 || tot_valid != v0) begin n_err++; $display("FAIL stop_err: got ferr=%0d valid=%0d want 1/0", tot_ferr - f0, tot_valid - v0); end
    endtask

    task automatic test_glitch;
        logic seen_busy;
        int v0, p0, f0;
        v0 = tot_valid; p0 = tot_perr; f0 = tot_ferr;
        seen_busy = 1'b0;
        PS2Data = 1'b0;
        cycles(5);
        PS2Clk = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge Clk);
            if (i == 5) PS2Clk = 1'b1;
            if (Busy) seen_busy = 1'b1;
        end
        n_cmp++; if (seen_busy !== 1'b0) begin n_err++; $display("FAIL glitch5_busy: got %b want 0", seen_busy); end
        PS2Clk = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            @(negedge Clk);
            if (i == 10) begin
                n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL pulse9_early: got %b want 0", Busy); end
            end
            if (i == 11) begin
                n_cmp++; if (Busy !== 1'b1) begin n_err++; $display("FAIL pulse9_busy: got %b want 1", Busy); end
            end
            if (i == 9) PS2Clk = 1'b1;
        end
        PS2Data = 1'b1;
        cycles(20);
        Enable = 1'b0;
        cycles(3);
        Enable = 1'b1;
        cycles(3);
        n_cmp++; if (Busy !== 1'b0 || tot_valid + tot_perr + tot_ferr != v0 + p0 + f0) begin n_err++; $display("FAIL glitch_cleanup: got busy=%b pulses=%0d want 0/0", Busy, tot_valid + tot_perr + tot_ferr - v0 - p0 - f0); end
    endtask

    task automatic test_timeout;
        logic [7:0] d;
        int cnt, v0, f0;
        logic seen;
        d = 8'($urandom);
        v0 = tot_valid; f0 = tot_ferr;
        send_bits({d[2:0], 1'b0}, 4, 100);
        PS2Data = d[3];
        cycles(100);
        PS2Clk = 1'b0;
        cnt = 0; seen = 1'b0;
        while (cnt < TO + 1000 && !seen) begin
            @(negedge Clk);
            cnt++;
            if (cnt == 100) PS2Clk = 1'b1;
            if (FrameErr) seen = 1'b1;
        end
        PS2Data = 1'b1;
        // Bit taken FL+3 edges after the raw fall; abort TO edges after that.
        n_cmp++; if (!seen || cnt != FL + 3 + TO) begin n_err++; $display("FAIL timeout_latency: got seen=%b edges=%0d want %0d", seen, cnt, FL + 3 + TO); end
        cycles(5);
        n_cmp++; if (Busy !== 1'b0 || tot_ferr - f0 != 1 || tot_valid != v0) begin n_err++; $display("FAIL timeout_after: got busy=%b ferr=%0d valid=%0d want 0/1/0", Busy, tot_ferr - f0, tot_valid - v0); end
    endtask

    task automatic test_enable;
        logic [7:0] d;
        int tot0, oc, idx;
        d = 8'($urandom);
        tot0 = tot_valid + tot_perr + tot_ferr;
        send_bits({d[3:0], 1'b0}, 5, 100);
        n_cmp++; if (Busy !== 1'b1) begin n_err++; $display("FAIL enable_midframe_busy: got %b want 1", Busy); end
        Enable = 1'b0;
        cycles(20);
        Enable = 1'b1;
        cycles(300);
        n_cmp++; if (Busy !== 1'b0 || tot_valid + tot_perr + tot_ferr != tot0) begin n_err++; $display("FAIL enable_abort: got busy=%b pulses=%0d want 0/0", Busy, tot_valid + tot_perr + tot_ferr - tot0); end
        n_cmp++; if (Data !== exp_data) begin n_err++; $display("FAIL enable_data_hold: got %h want %h", Data, exp_data); end
        idx = cap_q.size();
        send_byte(8'hFA, 1'b0, 1'b0, 100, oc);
        n_cmp++; if (cap_q.size() - idx != 1 || Data !== 8'hFA) begin n_err++; $display("FAIL enable_resume: got n=%0d data=%h want 1/fa", cap_q.size() - idx, Data); end
    endtask

    task automatic test_reset_mid;
        int idx, oc;
        send_bits(11'b0000_0110_0, 4, 100);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        n_cmp++; if ({Data, Valid, ParityErr, FrameErr, Busy} !== 12'h000) begin n_err++; $display("FAIL reset_mid_outputs: got data=%h flags=%b want 00/0000", Data, {Valid, ParityErr, FrameErr, Busy}); end
        exp_data = 8'h00;
        cycles(3);
        Reset = 1'b1;
        cycles(30);
        idx = cap_q.size();
        send_byte(8'hAA, 1'b0, 1'b0, 100, oc);
        n_cmp++; if (cap_q.size() - idx != 1 || Data !== 8'hAA) begin n_err++; $display("FAIL reset_mid_next: got n=%0d data=%h want 1/aa", cap_q.size() - idx, Data); end
    endtask

    task automatic test_random;
        logic [7:0] d;
        logic bp, bs;
        int half, oc, v0, p0, f0;
        for (int k = 0; k < 12; k++) begin
            d = 8'($urandom);
            bp = ($urandom % 4) == 0;
            bs = ($urandom % 6) == 0;
            half = $urandom_range(60, 20);
            v0 = tot_valid; p0 = tot_perr; f0 = tot_ferr;
            send_byte(d, bp, bs, half, oc);
            n_cmp++;
            if ((tot_valid - v0) != int'(oc == 0) || (tot_perr - p0) != int'(oc == 1) || (tot_ferr - f0) != int'(oc == 2)) begin
                n_err++;
                $display("FAIL rand_pulses[%0d]: got v/p/f=%0d/%0d/%0d want outcome %0d for %h", k, tot_valid - v0, tot_perr - p0, tot_ferr - f0, oc, d);
            end
            n_cmp++; if (Data !== exp_data) begin n_err++; $display("FAIL rand_data[%0d]: got %h want %h", k, Data, exp_data); end
        end
        n_cmp++; if (tot_multi != 0) begin n_err++; $display("FAIL exclusive_pulses: got %0d overlaps want 0", tot_multi); end
    endtask

    initial begin
        test_reset();
        test_fa();
        test_back_to_back();
        test_errors();
        test_glitch();
        test_timeout();
        test_enable();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
